mdu_iter: RTL

Parametrised multiply/divide unit for the MIPS datapath EX stage. It owns the HI/LO register pair and implements:
- unsigned and signed multiply;
- multiply-accumulate and multiply-subtract into HI/LO;
- unsigned and signed division, as a true iterative restoring divider, one quotient bit per cycle;
- direct HI/LO writes (MTHI/MTLO).

The pipeline stalls on Busy. The block also supports aborting an in-flight operation on exception flush.

---
 rtl/mdu_iter_if.sv | 27 ++
 rtl/mdu_iter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The EX stage is the master and the mdu_iter block is the slave.
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] D1;
   logic [WIDTH-1:0] D2;
   logic [2:0]       Op;
   logic             Start;
   logic             We;
   logic             HiLo;
   logic             Cancel;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (
      output D1, D2, Op, Start, We, HiLo, Cancel,
      input  Busy, Done, HI, LO
   );

   modport slave (
      input  D1, D2, Op, Start, We, HiLo, Cancel,
      output Busy, Done, HI, LO
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO: MUL_LAT-cycle multiply/madd/msub,
// WIDTH+1-cycle restoring divide. Define MDU_CANCEL_EN to let Cancel abort an operation.
module mdu_iter #(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 4
) (
   input logic     Clk,
   input logic     Rst,
   mdu_iter_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
   localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             neg_q, neg_d;
   logic             rsign_q, rsign_d;
   logic             done_q, done_d;

   logic cancel;
`ifdef MDU_CANCEL_EN
   assign cancel = bus.Cancel;
`else
   logic unused_cancel;
   assign cancel        = 1'b0;
   assign unused_cancel = bus.Cancel;
`endif

   // Multiply datapath: operands sign- or zero-extended so one 2W multiplier serves both.
   logic [2*WIDTH-1:0] ext_a, ext_b, product, acc, mul_res;
   always_comb begin
      ext_a   = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      ext_b   = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      product = ext_a * ext_b;
      acc     = {hi_q, lo_q};
      case (op_q[2:1])
         2'b10:   mul_res = acc + product;
         2'b11:   mul_res = acc - product;
         default: mul_res = product;
      endcase
   end

   // Divide datapath: b_q holds |divisor|, quo_q shifts dividend bits out and quotient bits in.
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_sub, abs_d1, abs_d2, q_fix, r_fix;
   logic             take, is_mul_op, div_zero;
   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      rem_sub   = rem_shift[WIDTH-1:0] - b_q;
      take      = (rem_shift >= {1'b0, b_q});
      abs_d1    = (bus.Op[0] && bus.D1[WIDTH-1]) ? -bus.D1 : bus.D1;
      abs_d2    = (bus.Op[0] && bus.D2[WIDTH-1]) ? -bus.D2 : bus.D2;
      is_mul_op = bus.Op[2] | ~bus.Op[1];
      q_fix     = neg_q ? -quo_q : quo_q;
      r_fix     = rsign_q ? -rem_q : rem_q;
      div_zero  = (b_q == '0);
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      neg_d   = neg_q;
      rsign_d = rsign_q;
      done_d  = 1'b0;
      if (cancel) begin
         state_d = S_IDLE;
         count_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.Start) begin
                  op_d = bus.Op;
                  a_d  = bus.D1;
                  if (is_mul_op) begin
                     b_d     = bus.D2;
                     state_d = S_MUL;
                     count_d = CW'(MUL_LAT - 1);
                  end else begin
                     b_d     = abs_d2;
                     quo_d   = abs_d1;
                     rem_d   = '0;
                     neg_d   = bus.Op[0] & (bus.D1[WIDTH-1] ^ bus.D2[WIDTH-1]);
                     rsign_d = bus.Op[0] & bus.D1[WIDTH-1];
                     state_d = S_DIV;
                     count_d = CW'(WIDTH - 1);
                  end
               end else if (bus.We) begin
                  if (bus.HiLo) hi_d = bus.D1;
                  else          lo_d = bus.D1;
               end
            end
            S_MUL: begin
               if (count_q == '0) begin
                  {hi_d, lo_d} = mul_res;
                  done_d       = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  count_d = count_q - CW'(1);
               end
            end
            S_DIV: begin
               quo_d = {quo_q[WIDTH-2:0], take};
               rem_d = take ? rem_sub : rem_shift[WIDTH-1:0];
               if (count_q == '0) state_d = S_FIX;
               else               count_d = count_q - CW'(1);
            end
            default: begin
               // Divide by zero returns a fixed pattern rather than trapping.
               if (div_zero) begin
                  lo_d = '1;
                  hi_d = a_q;
               end else begin
                  lo_d = q_fix;
                  hi_d = r_fix;
               end
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         neg_q   <= 1'b0;
         rsign_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         neg_q   <= neg_d;
         rsign_q <= rsign_d;
         done_q  <= done_d;
      end
   end

   assign bus.Busy = (state_q != S_IDLE);
   assign bus.Done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;
endmodule
